output_buffer: RTL and testbench

- Store-side peripheral block of the LSU. It is the write-direction counterpart of the switch/button input path.
- Holds memory-mapped output registers for red LEDs, green LEDs, eight 7-segment digits and the LCD.
- Accepts byte, half and word stores from the LSU and provides a full-word readback for loads.
- Generates a timed LCD enable strobe through a small state machine.

---
 rtl/output_buffer.sv | 239 +++++++++++++++++++++++
 tb/tb_output_buffer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/output_buffer.sv
// output_buffer: memory-mapped output registers (LEDR, LEDG, 8x HEX, LCD)
// written by byte/half/word stores from the LSU, with full-word readback and
// a timed LCD enable strobe that is inserted into bit 10 of the LCD output.
module output_buffer #(
   parameter int LCD_PULSE = 4,
   parameter int LCD_HOLD  = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_st_en,
   input  logic [6:0]  i_addr,
   input  logic [1:0]  i_st_size,
   input  logic [31:0] i_st_data,
   output logic [31:0] o_rdata,
   output logic        o_st_err,
   output logic        o_lcd_busy,
   output logic [31:0] o_io_ledr,
   output logic [31:0] o_io_ledg,
   output logic [6:0]  o_io_hex0,
   output logic [6:0]  o_io_hex1,
   output logic [6:0]  o_io_hex2,
   output logic [6:0]  o_io_hex3,
   output logic [6:0]  o_io_hex4,
   output logic [6:0]  o_io_hex5,
   output logic [6:0]  o_io_hex6,
   output logic [6:0]  o_io_hex7,
   output logic [31:0] o_io_lcd
);

   // Counter must hold the larger of LCD_PULSE-1 and LCD_HOLD-1.
   localparam int CNT_MAX = (LCD_PULSE > LCD_HOLD) ? LCD_PULSE : LCD_HOLD;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [2:0] SEL_LEDR   = 3'd0;
   localparam logic [2:0] SEL_LEDG   = 3'd1;
   localparam logic [2:0] SEL_HEX_LO = 3'd2;
   localparam logic [2:0] SEL_HEX_HI = 3'd3;
   localparam logic [2:0] SEL_LCD    = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PULSE,
      ST_HOLD
   } lcd_state_e;

   lcd_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [31:0] ledr_q, ledr_d;
   logic [31:0] ledg_q, ledg_d;
   logic [31:0] lcd_q,  lcd_d;
   logic [6:0]  hex_q [8];
   logic [6:0]  hex_d [8];

   logic [2:0]  sel;
   logic [1:0]  offset;
   logic        align_ok;
   logic [3:0]  lane_en;
   logic [31:0] wdata;
   logic        lcd_blocked;
   logic        store_ok;
   logic        lcd_start;
   logic        lcd_en;
   logic        lcd_busy;

   // Address bits [3:2] carry no meaning inside this region.
   logic        unused_addr_bits;
   assign unused_addr_bits = ^i_addr[3:2];

   assign sel    = i_addr[6:4];
   assign offset = i_addr[1:0];

   // Decode store size into alignment legality, lane enables and replicated data.
   always_comb begin
      align_ok = 1'b0;
      lane_en  = 4'b0000;
      wdata    = i_st_data;
      case (i_st_size)
         2'b00: begin
            align_ok = 1'b1;
            lane_en  = 4'b0001 << offset;
            wdata    = {4{i_st_data[7:0]}};
         end
         2'b01: begin
            align_ok = ~offset[0];
            lane_en  = offset[1] ? 4'b1100 : 4'b0011;
            wdata    = {2{i_st_data[15:0]}};
         end
         2'b10: begin
            align_ok = (offset == 2'b00);
            lane_en  = 4'b1111;
            wdata    = i_st_data;
         end
         default: begin
            align_ok = 1'b0;
            lane_en  = 4'b0000;
            wdata    = i_st_data;
         end
      endcase
   end

   assign lcd_blocked = (sel == SEL_LCD) && lcd_busy;
   assign store_ok    = i_st_en && align_ok && !lcd_blocked;
   assign o_st_err    = i_st_en && !(align_ok && !lcd_blocked);
   assign lcd_start   = store_ok && (sel == SEL_LCD);

   // Merge the enabled byte lanes of the store into the selected register.
   always_comb begin
      ledr_d = ledr_q;
      ledg_d = ledg_q;
      lcd_d  = lcd_q;
      for (int i = 0; i < 8; i++) begin
         hex_d[i] = hex_q[i];
      end
      for (int l = 0; l < 4; l++) begin
         if (store_ok && lane_en[l]) begin
            case (sel)
               SEL_LEDR:   ledr_d[8*l +: 8] = wdata[8*l +: 8];
               SEL_LEDG:   ledg_d[8*l +: 8] = wdata[8*l +: 8];
               SEL_HEX_LO: hex_d[l]         = wdata[8*l +: 7];
               SEL_HEX_HI: hex_d[l+4]       = wdata[8*l +: 7];
               SEL_LCD:    lcd_d[8*l +: 8]  = wdata[8*l +: 8];
               default: ;
            endcase
         end
      end
   end

   // Output registers; HEX digits reset to blank (all segments off).
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         ledr_q <= '0;
         ledg_q <= '0;
         lcd_q  <= '0;
         for (int i = 0; i < 8; i++) begin
            hex_q[i] <= 7'h7F;
         end
      end else begin
         ledr_q <= ledr_d;
         ledg_q <= ledg_d;
         lcd_q  <= lcd_d;
         for (int i = 0; i < 8; i++) begin
            hex_q[i] <= hex_d[i];
         end
      end
   end

   // LCD strobe state and cycle counter.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Strobe sequencing: PULSE for LCD_PULSE cycles, then HOLD for LCD_HOLD cycles.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (lcd_start) begin
               state_d = ST_PULSE;
               cnt_d   = CNT_W'(LCD_PULSE - 1);
            end
         end
         ST_PULSE: begin
            if (cnt_q == '0) begin
               if (LCD_HOLD == 0) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_HOLD;
                  cnt_d   = CNT_W'(LCD_HOLD - 1);
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Strobe outputs decoded from the current state.
   always_comb begin
      lcd_en   = 1'b0;
      lcd_busy = 1'b0;
      case (state_q)
         ST_PULSE: begin
            lcd_en   = 1'b1;
            lcd_busy = 1'b1;
         end
         ST_HOLD: begin
            lcd_busy = 1'b1;
         end
         default: ;
      endcase
   end

   // Readback of the selected register; unmapped slots read as zero.
   always_comb begin
      o_rdata = '0;
      case (sel)
         SEL_LEDR:   o_rdata = ledr_q;
         SEL_LEDG:   o_rdata = ledg_q;
         SEL_HEX_LO: o_rdata = {1'b0, hex_q[3], 1'b0, hex_q[2], 1'b0, hex_q[1], 1'b0, hex_q[0]};
         SEL_HEX_HI: o_rdata = {1'b0, hex_q[7], 1'b0, hex_q[6], 1'b0, hex_q[5], 1'b0, hex_q[4]};
         SEL_LCD:    o_rdata = lcd_q;
         default:    o_rdata = '0;
      endcase
   end

   assign o_lcd_busy = lcd_busy;
   assign o_io_ledr  = ledr_q;
   assign o_io_ledg  = ledg_q;
   assign o_io_hex0  = hex_q[0];
   assign o_io_hex1  = hex_q[1];
   assign o_io_hex2  = hex_q[2];
   assign o_io_hex3  = hex_q[3];
   assign o_io_hex4  = hex_q[4];
   assign o_io_hex5  = hex_q[5];
   assign o_io_hex6  = hex_q[6];
   assign o_io_hex7  = hex_q[7];
   assign o_io_lcd   = {lcd_q[31:11], lcd_en, lcd_q[9:0]};

endmodule

// File: tb/tb_output_buffer.sv
// Self-checking bench for output_buffer: a table of stores with expected
// error flag and register contents (queued as a scoreboard and compared after
// the store edge), plus hand-written LCD strobe and mid-pulse reset sequences.
module tb_output_buffer;

   logic        clk;
   logic        rstN;
   logic        stEn;
   logic [6:0]  addr;
   logic [1:0]  stSize;
   logic [31:0] stData;
   logic [31:0] rdata;
   logic        stErr;
   logic        lcdBusy;
   logic [31:0] ioLedr;
   logic [31:0] ioLedg;
   logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
   logic [31:0] ioLcd;

   int nChecks = 0;
   int nFail   = 0;

   typedef struct {
      logic [6:0]  addr;
      logic [1:0]  size;
      logic [31:0] data;
      logic        expErr;
      logic [31:0] expReg;
   } vec_t;

   typedef struct {
      logic [2:0]  sel;
      logic [31:0] val;
   } sb_t;

   vec_t vecs [10];
   sb_t  sbQueue [$];

   output_buffer #(.LCD_PULSE(4), .LCD_HOLD(8)) dut (
      .i_clk      (clk),
      .i_rst      (rstN),
      .i_st_en    (stEn),
      .i_addr     (addr),
      .i_st_size  (stSize),
      .i_st_data  (stData),
      .o_rdata    (rdata),
      .o_st_err   (stErr),
      .o_lcd_busy (lcdBusy),
      .o_io_ledr  (ioLedr),
      .o_io_ledg  (ioLedg),
      .o_io_hex0  (hex0),
      .o_io_hex1  (hex1),
      .o_io_hex2  (hex2),
      .o_io_hex3  (hex3),
      .o_io_hex4  (hex4),
      .o_io_hex5  (hex5),
      .o_io_hex6  (hex6),
      .o_io_hex7  (hex7),
      .o_io_lcd   (ioLcd)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one value and count the result
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Select a register for readback with no store, then compare
   task automatic readCheck(input string name, input logic [2:0] sel, input logic [31:0] expected);
      stEn = 1'b0;
      addr = {sel, 4'b0000};
      #1;
      checkOutput(name, rdata, expected);
   endtask

   // Drive one store between edges, check the error flag, queue the expected register value
   task automatic applyStimulus(input vec_t v);
      sb_t entry;
      @(negedge clk);
      stEn   = 1'b1;
      addr   = v.addr;
      stSize = v.size;
      stData = v.data;
      #1;
      checkOutput($sformatf("st_err addr=%02h", v.addr), {31'b0, stErr}, {31'b0, v.expErr});
      entry.sel = v.addr[6:4];
      entry.val = v.expReg;
      sbQueue.push_back(entry);
      @(posedge clk);
      #1;
      stEn = 1'b0;
   endtask

   initial begin
      sb_t exp;
      int  enCount;

      vecs[0] = '{7'h00, 2'b10, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
      vecs[1] = '{7'h02, 2'b00, 32'h00000055, 1'b0, 32'hDE55BEEF};
      vecs[2] = '{7'h11, 2'b01, 32'h00001234, 1'b1, 32'h00000000};
      vecs[3] = '{7'h12, 2'b01, 32'h00001234, 1'b0, 32'h12340000};
      vecs[4] = '{7'h30, 2'b10, 32'h80C0F9A4, 1'b0, 32'h00407924};
      vecs[5] = '{7'h21, 2'b00, 32'h00000006, 1'b0, 32'h7F7F067F};
      vecs[6] = '{7'h10, 2'b11, 32'hFFFFFFFF, 1'b1, 32'h12340000};
      vecs[7] = '{7'h02, 2'b10, 32'h00000000, 1'b1, 32'hDE55BEEF};
      vecs[8] = '{7'h50, 2'b10, 32'hFFFFFFFF, 1'b0, 32'h00000000};
      vecs[9] = '{7'h10, 2'b01, 32'h0000ABCD, 1'b0, 32'h1234ABCD};

      rstN   = 1'b0;
      stEn   = 1'b0;
      addr   = '0;
      stSize = 2'b00;
      stData = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstN = 1'b1;

      // Reset state
      readCheck("reset LEDR",   3'd0, 32'h0);
      readCheck("reset LEDG",   3'd1, 32'h0);
      readCheck("reset HEX_LO", 3'd2, 32'h7F7F7F7F);
      readCheck("reset HEX_HI", 3'd3, 32'h7F7F7F7F);
      readCheck("reset LCD",    3'd4, 32'h0);
      checkOutput("reset io_lcd", ioLcd, 32'h0);
      checkOutput("reset busy", {31'b0, lcdBusy}, 32'h0);
      checkOutput("reset hex0", {25'b0, hex0}, 32'h7F);
      checkOutput("reset hex7", {25'b0, hex7}, 32'h7F);

      // Table of stores; each expected register value is checked the cycle after
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i]);
         if (sbQueue.size() == 0) begin
            checkOutput("scoreboard underflow", 32'h1, 32'h0);
         end else begin
            exp = sbQueue.pop_front();
            readCheck($sformatf("readback vec%0d", i), exp.sel, exp.val);
         end
      end

      // Direct output pins after the table
      checkOutput("io_ledr", ioLedr, 32'hDE55BEEF);
      checkOutput("io_ledg", ioLedg, 32'h1234ABCD);
      checkOutput("hex4", {25'b0, hex4}, 32'h24);
      checkOutput("hex5", {25'b0, hex5}, 32'h79);
      checkOutput("hex6", {25'b0, hex6}, 32'h40);
      checkOutput("hex7", {25'b0, hex7}, 32'h00);
      checkOutput("hex1", {25'b0, hex1}, 32'h06);

      // Same-cycle store and read returns the old value
      @(negedge clk);
      stEn = 1'b1; addr = 7'h00; stSize = 2'b10; stData = 32'h11111111;
      #1;
      checkOutput("read-during-store old", rdata, 32'hDE55BEEF);
      @(posedge clk);
      #1;
      stEn = 1'b0;
      checkOutput("read-after-store new", rdata, 32'h11111111);

      // LCD strobe: 4 cycles EN, 12 cycles busy; store during busy dropped, LEDR accepted
      @(negedge clk);
      stEn = 1'b1; addr = 7'h40; stSize = 2'b10; stData = 32'h80000441;
      #1;
      checkOutput("lcd store err", {31'b0, stErr}, 32'h0);
      @(posedge clk);
      #1;
      stEn = 1'b0;
      for (int k = 0; k < 14; k++) begin
         checkOutput($sformatf("lcd en k=%0d", k), {31'b0, ioLcd[10]}, {31'b0, (k < 4)});
         checkOutput($sformatf("lcd busy k=%0d", k), {31'b0, lcdBusy}, {31'b0, (k < 12)});
         checkOutput($sformatf("io_lcd k=%0d", k), ioLcd, (k < 4) ? 32'h80000441 : 32'h80000041);
         if (k == 7) checkOutput("ledr during busy", ioLedr, 32'h0000CAFE);
         stEn = 1'b0;
         if (k == 5) begin
            stEn = 1'b1; addr = 7'h40; stSize = 2'b10; stData = 32'h12345678;
            #1;
            checkOutput("lcd store while busy err", {31'b0, stErr}, 32'h1);
         end else if (k == 6) begin
            stEn = 1'b1; addr = 7'h00; stSize = 2'b10; stData = 32'h0000CAFE;
            #1;
            checkOutput("ledr store while busy err", {31'b0, stErr}, 32'h0);
         end
         @(posedge clk);
         #1;
      end
      stEn = 1'b0;
      readCheck("lcd readback keeps bit10", 3'd4, 32'h80000441);

      // Reset in the 2nd PULSE cycle aborts the strobe and clears registers
      @(negedge clk);
      stEn = 1'b1; addr = 7'h40; stSize = 2'b10; stData = 32'h00000400;
      @(posedge clk);
      #1;
      stEn = 1'b0;
      @(posedge clk);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("async rst en", {31'b0, ioLcd[10]}, 32'h0);
      checkOutput("async rst busy", {31'b0, lcdBusy}, 32'h0);
      checkOutput("async rst ledr", ioLedr, 32'h0);
      checkOutput("async rst ledg", ioLedg, 32'h0);
      checkOutput("async rst hex4", {25'b0, hex4}, 32'h7F);
      checkOutput("async rst lcd", ioLcd, 32'h0);
      @(negedge clk);
      rstN = 1'b1;

      // Fresh strobe after reset release
      @(negedge clk);
      stEn = 1'b1; addr = 7'h40; stSize = 2'b10; stData = 32'h00000001;
      #1;
      checkOutput("post-reset lcd err", {31'b0, stErr}, 32'h0);
      @(posedge clk);
      #1;
      stEn = 1'b0;
      enCount = 0;
      for (int k = 0; k < 16; k++) begin
         if (ioLcd[10]) enCount++;
         @(posedge clk);
         #1;
      end
      checkOutput("post-reset pulse length", enCount, 32'd4);
      checkOutput("post-reset idle busy", {31'b0, lcdBusy}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
